// File: rtl/addsub_ctrl.sv
// addsub_ctrl: command FIFO plus sequencer for an external add/subtract datapath.
// Commands are queued, issued one at a time to the datapath, and the result is
// captured after a fixed latency and held until the consumer accepts it.
// Optional result checker: define ADDSUB_CTRL_CHECK_EN to enable the sticky oERR flag.

module addsub_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LATENCY    = 1
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iCMD_VALID,
    output logic       oCMD_READY,
    input  logic       iCMD_OPCODE,
    input  logic [7:0] iCMD_A,
    input  logic [7:0] iCMD_B,
    output logic       oOPCODE,
    output logic [7:0] oDATAIN1,
    output logic [7:0] oDATAIN2,
    input  logic [7:0] iDATAOUT,
    output logic       oRSP_VALID,
    input  logic       iRSP_READY,
    output logic [7:0] oRSP_DATA,
    output logic       oERR
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = 17;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [EntW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full;
    logic            push;
    logic            pop;
    logic [EntW-1:0] head;
    logic            head_op;
    logic [7:0]      head_a;
    logic [7:0]      head_b;

    // ------------------------------------------------------------------
    // Sequencer and output registers
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load;
    logic       capture;
    logic       rsp_done;
    logic       op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;

    // Ready depends only on the registered occupancy, so a pop in the same
    // cycle never opens a slot early; reset also holds it low.
    assign full       = (count_q == CntW'(FIFO_DEPTH));
    assign oCMD_READY = ~full & ~iRST;
    assign push       = iCMD_VALID & oCMD_READY;
    assign pop        = load;

    assign head    = mem_q[rd_ptr_q];
    assign head_op = head[16];
    assign head_a  = head[15:8];
    assign head_b  = head[7:0];

    // FIFO storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {iCMD_OPCODE, iCMD_A, iCMD_B};
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer next-state: issue head, count down the datapath latency, hold the response
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Only registered occupancy is looked at, so a fresh push waits one cycle
                if (count_q != '0) begin
                    load    = 1'b1;
                    cnt_d   = 3'(LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                if (iRSP_READY) begin
                    rsp_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operand and response register next-state
    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (load) begin
            op_d = head_op;
            a_d  = head_a;
            b_d  = head_b;
        end
        if (capture) begin
            rsp_data_d  = iDATAOUT;
            rsp_valid_d = 1'b1;
        end else if (rsp_done) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Sequencer, operand and response state registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign oOPCODE    = op_q;
    assign oDATAIN1   = a_q;
    assign oDATAIN2   = b_q;
    assign oRSP_VALID = rsp_valid_q;
    assign oRSP_DATA  = rsp_data_q;

    // ------------------------------------------------------------------
    // Optional result checker
    // ------------------------------------------------------------------
`ifdef ADDSUB_CTRL_CHECK_EN
    logic [7:0] exp_q, exp_d;
    logic       err_q, err_d;

    // Expected result is latched at issue and compared at capture; mismatch is sticky
    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        if (load) begin
            exp_d = head_op ? (head_a - head_b) : (head_a + head_b);
        end
        if (capture && (iDATAOUT != exp_q)) begin
            err_d = 1'b1;
        end
    end

    // Checker state register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign oERR = err_q;
`else
    assign oERR = 1'b0;
`endif

endmodule

// File: doc/addsub_ctrl.md
ADDSUB_CTRL -- requirements
Module: addsub_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter LATENCY, default 1, cycles from operand drive to valid iDATAOUT; SHALL be 1..7.
REQ-003 iCLK  input  1  single clock; all state SHALL update on rising edge.
REQ-004 iRST  input  1  reset, synchronous, active-high.
REQ-005 iCMD_VALID  input  1  command present.
REQ-006 oCMD_READY  output  1  FIFO can accept command.
REQ-007 iCMD_OPCODE  input  1  0 = add, 1 = subtract.
REQ-008 iCMD_A  input  8  first operand.
REQ-009 iCMD_B  input  8  second operand.
REQ-010 oOPCODE  output  1  opcode driven to addsub datapath.
REQ-011 oDATAIN1  output  8  first operand driven to addsub datapath.
REQ-012 oDATAIN2  output  8  second operand driven to addsub datapath.
REQ-013 iDATAOUT  input  8  result returned from addsub datapath.
REQ-014 oRSP_VALID  output  1  result available.
REQ-015 iRSP_READY  input  1  consumer accepts result.
REQ-016 oRSP_DATA  output  8  captured result.
REQ-017 oERR  output  1  sticky result-mismatch flag (see Configuration).

Function
REQ-018 Command SHALL be pushed when iCMD_VALID and oCMD_READY are both high on a rising edge.
REQ-019 oCMD_READY SHALL equal not-full, registered-state based; a pop in the same cycle SHALL NOT raise ready when full.
REQ-020 Push while empty and IDLE SHALL NOT bypass the FIFO; entry becomes visible to the FSM the next cycle.
REQ-021 Simultaneous push and pop SHALL keep occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 FSM states SHALL be IDLE, WAIT, RESP.
REQ-023 IDLE with FIFO non-empty: load head into oOPCODE/oDATAIN1/oDATAIN2, pop, load counter with LATENCY, go WAIT.
REQ-024 WAIT: decrement counter each cycle; on the cycle counter reaches 0, capture iDATAOUT into oRSP_DATA, set oRSP_VALID, go RESP.
REQ-025 Capture SHALL occur exactly LATENCY+1 edges after the load edge.
REQ-026 RESP: hold oRSP_VALID and oRSP_DATA stable until iRSP_READY high on an edge; then clear oRSP_VALID, go IDLE.
REQ-027 Operand outputs SHALL hold last loaded values until next load.
REQ-028 Results SHALL be returned in command order; one operation in flight maximum.
REQ-029 Arithmetic is modulo 256: add = A+B, subtract = A-B two's complement; no carry/borrow output.

Reset
REQ-030 While iRST high: FIFO empty, state IDLE, counter 0, oCMD_READY 0, oRSP_VALID 0, oRSP_DATA 0, oOPCODE 0, oDATAIN1 0, oDATAIN2 0, oERR 0.
REQ-031 oCMD_READY SHALL be 1 the first cycle after iRST deasserts.
REQ-032 Reset mid-operation SHALL discard in-flight operation and all queued commands; no response emitted.

Configuration
REQ-033 Macro ADDSUB_CTRL_CHECK_EN defined: at load compute expected result per REQ-029; at capture compare with iDATAOUT; mismatch sets oERR, held until reset.
REQ-034 Macro undefined: oERR port SHALL exist and be tied 0; no checker logic.

Verification
REQ-035 Reset, then one add A=8'h01 B=8'h03, iRSP_READY=1 -> oRSP_DATA=8'h04, oRSP_VALID high exactly LATENCY+2 cycles after push edge, oERR=0.
REQ-036 Subtract A=8'h03 B=8'h05 -> oRSP_DATA=8'hFE; add A=8'hFF B=8'h02 -> 8'h01 (wrap).
REQ-037 iRSP_READY=0, push 5 commands back-to-back -> oCMD_READY low after 4th accepted entry plus one in flight; 6th held off; releasing ready returns all results in push order.
REQ-038 Assert iRST during WAIT with 3 queued -> next cycle all outputs 0, no oRSP_VALID afterward, oCMD_READY=1 after release.
REQ-039 With ADDSUB_CTRL_CHECK_EN and model corrupting one result (add 8'h10+8'h20 returns 8'h31) -> oERR rises at that capture and stays 1 until reset; without macro oERR stays 0.
REQ-040 Sweep LATENCY=1 and 7 with 10 random commands -> every result matches model, capture timing per REQ-025.
